// File: rtl/dsq_capture.sv
// dsq_capture: synchronises din, samples it every DIV clocks and packs W samples per word (bit 0 oldest).
// Optional DSQ_GLITCH_FILT_EN inserts a 3-tap majority filter between the synchroniser and the shift register.
module dsq_capture #(
  parameter int W   = 32,
  parameter int DIV = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         din,
  input  logic         en,
  output logic [W-1:0] dsq,
  output logic         dsq_vld,
  output logic [31:0]  wcnt,
  output logic         busy
);

  // state | meaning
  // IDLE  | capture stopped, prescaler and bit counter held at 0
  // RUN   | sampling on every prescaler strobe, emitting a word every W samples
  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam int BW = $clog2(W);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_busy;

  logic [1:0]      r_sync;
  logic            w_din_s;
  logic            w_samp;
  logic [PW-1:0]   r_pcnt;
  logic [BW-1:0]   r_bcnt;
  // Bit 0 of the packed word is always shifted out on the next sample, so it is never stored.
  logic [W-1:1]    r_sr;
  logic [W-1:0]    w_sr_nxt;
  logic            w_stb;
  logic            w_last;
  logic [W-1:0]    r_dsq;
  logic            r_dsq_vld;
  logic [31:0]     r_wcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b00;
    else        r_sync <= {r_sync[0], din};
  end

  assign w_din_s = r_sync[1];

`ifdef DSQ_GLITCH_FILT_EN
  logic [2:0] r_tap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_tap <= 3'b000;
    else        r_tap <= {r_tap[1:0], w_din_s};
  end

  assign w_samp = (r_tap[0] & r_tap[1]) | (r_tap[0] & r_tap[2]) | (r_tap[1] & r_tap[2]);
`else
  assign w_samp = w_din_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (en)  w_state_nxt = S_RUN;
      S_RUN:   if (!en) w_state_nxt = S_IDLE;
      default:          w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    if (r_state == S_RUN) w_busy = 1'b1;
  end

  assign w_stb    = (r_state == S_RUN) && (r_pcnt == PW'(DIV - 1));
  assign w_last   = w_stb && (r_bcnt == BW'(W - 1));
  assign w_sr_nxt = {w_samp, r_sr[W-1:1]};

  // Leaving RUN clears the counters so the next entry starts a fresh word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt <= '0;
      r_bcnt <= '0;
    end else if ((r_state != S_RUN) || !en) begin
      r_pcnt <= '0;
      r_bcnt <= '0;
    end else begin
      r_pcnt <= w_stb ? '0 : r_pcnt + PW'(1);
      if (w_stb) r_bcnt <= w_last ? '0 : r_bcnt + BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sr <= '0;
    else if (w_stb) r_sr <= w_sr_nxt[W-1:1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dsq     <= '0;
      r_dsq_vld <= 1'b0;
      r_wcnt    <= '0;
    end else begin
      r_dsq_vld <= w_last;
      if (w_last) begin
        r_dsq  <= w_sr_nxt;
        r_wcnt <= r_wcnt + 32'd1;
      end
    end
  end

  assign dsq     = r_dsq;
  assign dsq_vld = r_dsq_vld;
  assign wcnt    = r_wcnt;
  assign busy    = w_busy;

endmodule
